// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer: FSM states, error codes, byte merge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic APB_ERR_OKAY   = 1'b0;
  localparam logic APB_ERR_SLVERR = 1'b1;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// Register bank for the APB completer: byte-enabled write port, read mux and a
// constant read-only ID register at the top index.
module apb_slv_regfile
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001,
  localparam int                   IDX_W      = $clog2(NUM_REGS),
  localparam int                   NB         = DATA_WIDTH / 8
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NB-1:0]         wbe,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // The top slot is never written; reads of it return the ID constant instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (we && (widx != LAST_IDX)) begin
      for (int b = 0; b < NB; b++)
        regs[widx][8*b +: 8] <= byte_merge(regs[widx][8*b +: 8], wdata[8*b +: 8], wbe[b]);
    end
  end

  assign rdata = (ridx == LAST_IDX) ? ID_VALUE : regs[ridx];

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer: register bank with programmable wait states and PSLVERR decode.
// Define APB_SLV_PSTRB_EN to add the pstrb port and byte-masked writes.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001,
  localparam int                   IDX_W       = $clog2(NUM_REGS)
)(
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    wr_evt,
  output logic [IDX_W-1:0]        wr_idx
);

  localparam int               NB       = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [3:0]       WS_LOAD  = 4'(WAIT_STATES);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  setup, commit;
  logic                  err_q, err_in;
  logic                  pwrite_q;
  logic [IDX_W-1:0]      idx_q, idx_in;
  logic [DATA_WIDTH-1:0] pwdata_q, rd_q, rd_data;
  logic [NB-1:0]         be_q, be_in;

  // Error decode on the live setup-phase bus.
  always_comb begin
    idx_in = paddr[2 +: IDX_W];
    err_in = APB_ERR_OKAY;
    if (|paddr[ADDR_WIDTH-1:IDX_W+2])       err_in = APB_ERR_SLVERR;
    if (|paddr[1:0])                        err_in = APB_ERR_SLVERR;
    if (pwrite && (idx_in == LAST_IDX))     err_in = APB_ERR_SLVERR;
`ifdef APB_SLV_PSTRB_EN
    if (!pwrite && (|pstrb))                err_in = APB_ERR_SLVERR;
    be_in = pstrb;
`else
    be_in = '1;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    setup   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          setup   = 1'b1;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES > 0) ? WAIT : READY;
        end
      end
      WAIT: begin
        if (psel && penable) begin
          if (cnt_q <= 4'd1) state_d = READY;
          else               cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      READY: begin
        state_d = IDLE;
        commit  = psel && pwrite_q && (err_q == APB_ERR_OKAY);
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, counter, latched error/direction and write event.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= APB_ERR_OKAY;
      pwrite_q <= 1'b0;
      wr_evt   <= 1'b0;
      wr_idx   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup) begin
        err_q    <= err_in;
        pwrite_q <= pwrite;
      end
      wr_evt <= commit;
      if (commit) wr_idx <= idx_q;
    end
  end

  // Setup-phase capture: later bus changes within the transfer are ignored.
  always_ff @(posedge pclk) begin
    if (setup) begin
      idx_q    <= idx_in;
      pwdata_q <= pwdata;
      be_q     <= be_in;
      rd_q     <= (err_in == APB_ERR_SLVERR) ? '0 : rd_data;
    end
  end

  apb_slv_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (commit),
    .widx  (idx_q),
    .wdata (pwdata_q),
    .wbe   (be_q),
    .ridx  (idx_in),
    .rdata (rd_data)
  );

  assign pready  = (state_q == READY);
  assign pslverr = pready & err_q;
  assign prdata  = (pready && !pwrite_q) ? rd_q : '0;

endmodule
